// File: rtl/or1200_vlx_store_seq.sv
// or1200_vlx_store_seq: turns packed VLX words of 1..4 bytes into single-byte store requests.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   set_addr_i, addr_i            load base address (IDLE only), clears byte_cnt_o
//   word_valid_i, word_i,         packed word offer; first byte in word_i[31:24],
//   nbytes_i, flush_i             nbytes_i clamps to 4, flush_i marks the stream's last word
//   word_ready_o                  high in IDLE
//   st_req_o, st_addr_o,          byte store request held until st_ack_i
//   st_dat_o, st_last_o, st_ack_i
//   busy_o, done_o, byte_cnt_o    not IDLE, end-of-flushed-stream pulse, stored-byte count
// Optional: define OR1200_VLX_BYTE_STUFF_EN to insert a 0x00 store after every 0xFF byte.
module or1200_vlx_store_seq #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_addr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              word_valid_i,
  input  logic [31:0]       word_i,
  input  logic [2:0]        nbytes_i,
  input  logic              flush_i,
  output logic              word_ready_o,
  output logic              st_req_o,
  output logic [ADDR_W-1:0] st_addr_o,
  output logic [7:0]        st_dat_o,
  output logic              st_last_o,
  input  logic              st_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  byte_cnt_o
);
`ifdef OR1200_VLX_BYTE_STUFF_EN
  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif
  state_t            r_state;
  logic [31:0]       r_word;
  logic [2:0]        r_rem;
  logic              r_last;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_stuff_go;
  logic              w_in_stuff;
`ifdef OR1200_VLX_BYTE_STUFF_EN
  assign w_stuff_go = r_state == SEND && r_word[31:24] == 8'hFF;
  assign w_in_stuff = r_state == STUFF;
`else
  assign w_stuff_go = 1'b0;
  assign w_in_stuff = 1'b0;
`endif
  assign word_ready_o = r_state == IDLE;
  assign busy_o       = r_state != IDLE;
  assign st_req_o     = busy_o;
  assign st_addr_o    = r_addr;
  assign byte_cnt_o   = r_cnt;
  assign done_o       = r_done;
  assign st_dat_o     = r_state == SEND ? r_word[31:24] : 8'h00;
  // a final 0xFF hands the last marker on to its stuff byte; rem is already decremented in STUFF
  assign st_last_o    = r_last && (w_in_stuff ? r_rem == 3'd0
                                              : r_state == SEND && r_rem == 3'd1 && !w_stuff_go);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_rem   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (set_addr_i) begin
          r_addr <= addr_i;
          r_cnt  <= '0;
        end
        if (word_valid_i) begin
          if (nbytes_i != 3'd0) begin
            r_word  <= word_i;
            r_rem   <= nbytes_i > 3'd4 ? 3'd4 : nbytes_i;
            r_last  <= flush_i;
            r_state <= SEND;
          end else begin
            r_done <= flush_i;
          end
        end
      end else if (st_ack_i) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_in_stuff) begin
          r_state <= r_rem == 3'd0 ? IDLE : SEND;
          r_done  <= r_rem == 3'd0 && r_last;
        end else begin
          r_word <= r_word << 8;
          r_rem  <= r_rem - 3'd1;
`ifdef OR1200_VLX_BYTE_STUFF_EN
          if (w_stuff_go) r_state <= STUFF;
          else
`endif
          if (r_rem == 3'd1) begin
            r_state <= IDLE;
            r_done  <= r_last;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_or1200_vlx_store_seq.sv
// tb_or1200_vlx_store_seq: byte-queue model of the store sequencer plus directed literal checks.
module tb_or1200_vlx_store_seq;
`ifdef OR1200_VLX_BYTE_STUFF_EN
  localparam bit STF = 1'b1;
`else
  localparam bit STF = 1'b0;
`endif
  logic        clk_i = 1'b0;
  logic        rst_ni, set_addr_i, word_valid_i, flush_i, st_ack_i;
  logic [31:0] addr_i, word_i;
  logic [2:0]  nbytes_i;
  logic        word_ready_o, st_req_o, st_last_o, busy_o, done_o;
  logic [31:0] st_addr_o;
  logic [7:0]  st_dat_o;
  logic [15:0] byte_cnt_o;

  or1200_vlx_store_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .set_addr_i(set_addr_i), .addr_i(addr_i),
    .word_valid_i(word_valid_i), .word_i(word_i), .nbytes_i(nbytes_i), .flush_i(flush_i),
    .word_ready_o(word_ready_o), .st_req_o(st_req_o), .st_addr_o(st_addr_o),
    .st_dat_o(st_dat_o), .st_last_o(st_last_o), .st_ack_i(st_ack_i), .busy_o(busy_o),
    .done_o(done_o), .byte_cnt_o(byte_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {logic [31:0] a; logic [7:0] d; logic l;} st_t;
  typedef struct {logic [31:0] a; logic [7:0] d; logic l; int c;} ob_t;
  st_t         q[$];
  ob_t         obs[$];
  st_t         e;
  logic [31:0] m_addr;
  logic [15:0] m_cnt;
  logic        exp_done;
  logic [7:0]  b;
  logic        fin;
  int          n, cyc, ack_delay;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model: each accepted word expands into the exact list of stores it must produce
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      chk("rst_req", st_req_o, 0);
      chk("rst_ready", word_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_addr", st_addr_o, 0);
      chk("rst_cnt", byte_cnt_o, 0);
      chk("rst_dat", st_dat_o, 0);
      chk("rst_last", st_last_o, 0);
      q.delete();
      m_addr   = 0;
      m_cnt    = 0;
      exp_done = 0;
    end else begin
      chk("ready", word_ready_o, q.size() == 0);
      chk("busy", busy_o, q.size() != 0);
      chk("req", st_req_o, q.size() != 0);
      chk("done", done_o, exp_done);
      chk("cnt", byte_cnt_o, m_cnt);
      chk("addr", st_addr_o, q.size() != 0 ? q[0].a : m_addr);
      if (q.size() != 0) begin
        chk("dat", st_dat_o, q[0].d);
        chk("last", st_last_o, q[0].l);
      end
      exp_done = 0;
      if (q.size() != 0) begin
        if (st_ack_i) begin
          obs.push_back('{st_addr_o, st_dat_o, st_last_o, cyc});
          e        = q.pop_front();
          m_cnt    = m_cnt + 16'd1;
          exp_done = e.l;
        end
      end else begin
        if (set_addr_i) begin
          m_addr = addr_i;
          m_cnt  = 0;
        end
        if (word_valid_i) begin
          n = nbytes_i > 4 ? 4 : int'(nbytes_i);
          if (n == 0) exp_done = flush_i;
          for (int i = 0; i < n; i++) begin
            b   = word_i[31-8*i -: 8];
            fin = flush_i && i == n - 1;
            q.push_back('{m_addr, b, fin && !(STF && b == 8'hFF)});
            m_addr = m_addr + 1;
            if (STF && b == 8'hFF) begin
              q.push_back('{m_addr, 8'h00, fin});
              m_addr = m_addr + 1;
            end
          end
        end
      end
    end
  end

  // ack responder: acks after ack_delay waiting cycles per request
  initial begin
    int w;
    w = 0;
    st_ack_i = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!st_req_o) begin
        st_ack_i = 0;
        w = 0;
      end else if (w >= ack_delay) begin
        st_ack_i = 1;
        w = 0;
      end else begin
        st_ack_i = 0;
        w++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (word_ready_o) return;
      @(posedge clk_i);
      #1;
    end
    total++;
    bad++;
    $display("FAIL idle_timeout: got busy want idle");
  endtask

  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] w,
                      input logic [2:0] nb, input logic f);
    wait_idle();
    set_addr_i = s; addr_i = a;
    word_valid_i = 1; word_i = w; nbytes_i = nb; flush_i = f;
    @(posedge clk_i);
    #1;
    set_addr_i = 0; word_valid_i = 0; flush_i = 0;
  endtask

  localparam int NS = STF ? 6 : 4;
  logic [7:0]  t4_d[6];
  logic [31:0] a4;

  initial begin
    cyc = 0; ack_delay = 2;
    rst_ni = 0; set_addr_i = 0; addr_i = 0; word_valid_i = 0; word_i = 0; nbytes_i = 0; flush_i = 0;
    if (STF) t4_d = '{8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'h00};
    else     t4_d = '{8'h12, 8'hFF, 8'h34, 8'hFF, 8'h00, 8'h00};
    a4 = STF ? 32'h100C : 32'h100A;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    // reset in the middle of a transfer
    send(1, 32'h40, 32'h01020304, 4, 0);
    repeat (4) @(posedge clk_i);
    #2 rst_ni = 0;
    #1;
    chk("t1_req", st_req_o, 0);
    chk("t1_addr", st_addr_o, 0);
    chk("t1_cnt", byte_cnt_o, 0);
    chk("t1_busy", busy_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1;
    obs.delete();
    ack_delay = 0;
    send(0, 0, 32'hA1000000, 1, 1);
    wait_idle();
    chk("t1_n", obs.size(), 1);
    chk("t1_a0", obs[0].a, 0);
    chk("t1_d0", obs[0].d, 8'hA1);
    // address load then a full flushed word
    wait_idle();
    set_addr_i = 1; addr_i = 32'h1000;
    @(posedge clk_i);
    #1 set_addr_i = 0;
    obs.delete();
    send(0, 0, 32'h11223344, 4, 1);
    wait_idle();
    chk("t2_done", done_o, 1);
    chk("t2_cnt", byte_cnt_o, 4);
    chk("t2_n", obs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_a%0d", i), obs[i].a, 32'h1000 + i);
      chk($sformatf("t2_d%0d", i), obs[i].d, 8'h11 * (i + 1));
      chk($sformatf("t2_l%0d", i), obs[i].l, i == 3);
      chk($sformatf("t2_c%0d", i), obs[i].c, obs[0].c + i);
    end
    // partial word with stalled acks
    obs.delete();
    ack_delay = 3;
    send(0, 0, 32'hAABBCCDD, 2, 0);
    wait_idle();
    chk("t3_n", obs.size(), 2);
    chk("t3_d0", obs[0].d, 8'hAA);
    chk("t3_d1", obs[1].d, 8'hBB);
    chk("t3_a1", obs[1].a, 32'h1005);
    chk("t3_gap", obs[1].c - obs[0].c, 4);
    chk("t3_cnt", byte_cnt_o, 6);
    chk("t3_done", done_o, 0);
    // 0xFF bytes, stuffed or not depending on the build
    obs.delete();
    ack_delay = 0;
    send(0, 0, 32'h12FF34FF, 4, 1);
    wait_idle();
    chk("t4_n", obs.size(), NS);
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("t4_d%0d", i), obs[i].d, t4_d[i]);
      chk($sformatf("t4_a%0d", i), obs[i].a, 32'h1006 + i);
      chk($sformatf("t4_l%0d", i), obs[i].l, i == NS - 1);
    end
    chk("t4_cnt", byte_cnt_o, 6 + NS);
    chk("t4_done", done_o, 1);
    // inputs offered while busy are ignored
    obs.delete();
    ack_delay = 3;
    send(0, 0, 32'h01020304, 4, 0);
    chk("t5_busy", busy_o, 1);
    set_addr_i = 1; addr_i = 32'h5555; word_valid_i = 1; word_i = 32'hDEADBEEF; nbytes_i = 4; flush_i = 1;
    @(posedge clk_i);
    #1 set_addr_i = 0; word_valid_i = 0; flush_i = 0;
    wait_idle();
    chk("t5_n", obs.size(), 4);
    chk("t5_d3", obs[3].d, 8'h04);
    chk("t5_addr", st_addr_o, a4 + 4);
    // empty flushed word
    obs.delete();
    ack_delay = 0;
    send(0, 0, 32'h0, 0, 1);
    chk("t6_done", done_o, 1);
    chk("t6_busy", busy_o, 0);
    @(posedge clk_i);
    #1;
    chk("t6_done_off", done_o, 0);
    chk("t6_n", obs.size(), 0);
    // address wrap with same-cycle load
    obs.delete();
    send(1, 32'hFFFFFFFE, 32'h0A0B0C00, 3, 1);
    wait_idle();
    chk("t7_a0", obs[0].a, 32'hFFFFFFFE);
    chk("t7_a2", obs[2].a, 32'h0);
    chk("t7_d2", obs[2].d, 8'h0C);
    chk("t7_addr", st_addr_o, 32'h1);
    chk("t7_cnt", byte_cnt_o, 3);
    // nbytes above 4 clamps
    obs.delete();
    send(0, 0, 32'h31323334, 7, 1);
    wait_idle();
    chk("t8_n", obs.size(), 4);
    chk("t8_d3", obs[3].d, 8'h34);
    chk("t8_l3", obs[3].l, 1);
    chk("t8_addr", st_addr_o, 32'h5);
    repeat (3) @(posedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
